// File: rtl/scoreboard_pkg.sv
// Shared types and seven-segment helpers for the match scoreboard.
package scoreboard_pkg;

    typedef enum logic {StPlay, StOver} state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    // Binary to four-digit BCD, used for elaboration-time constants only.
    function automatic logic [15:0] to_bcd(input int unsigned value);
        int unsigned v;
        v = value;
        to_bcd = '0;
        for (int i = 0; i < 4; i++) begin
            to_bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit saturating BCD counter with synchronous clear and increment enable.
module bcd_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [DIGITS*4-1:0]   count_o
);

    logic [DIGITS*4-1:0] count_q, count_d;
    logic                all_nine;
    logic                carry;

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (count_q[i*4 +: 4] != 4'd9) all_nine = 1'b0;
        end

        count_d = count_q;
        carry   = inc_i && !all_nine;
        // Ripple the carry from the least significant digit upwards.
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_d[i*4 +: 4] = 4'd0;
                end else begin
                    count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end

        if (clr_i) count_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/match_scoreboard.sv
// Multi-player BCD match scoreboard with seven-segment outputs.
// Define SCOREBOARD_DRAW_CNT_EN to count drawn rounds in draw_count.
module match_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned WIN_SCORE   = 5
) (
    input  logic                            clk,
    input  logic                            clear_b,
    input  logic                            round_valid,
    input  logic [NUM_PLAYERS-1:0]          round_winner,
    input  logic                            new_match,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] scores_bcd,
    output logic [NUM_PLAYERS*DIGITS*7-1:0] hex_segs,
    output logic                            match_over,
    output logic [NUM_PLAYERS-1:0]          match_winner,
    output logic [DIGITS*4-1:0]             draw_count
);

    localparam int unsigned W = DIGITS * 4;
    // A win happens when a score sitting at WIN_SCORE-1 is incremented.
    localparam logic [W-1:0] WIN_PREV_BCD = W'(to_bcd((WIN_SCORE == 0) ? 0 : WIN_SCORE - 1));

    state_e                 state_q, state_d;
    logic [NUM_PLAYERS-1:0] winner_q, winner_d;
    logic [NUM_PLAYERS-1:0] inc;
    logic                   accept;
    logic                   win_hit;

    assign accept = round_valid && (state_q == StPlay) && !new_match;
    assign inc    = (accept && $onehot(round_winner)) ? round_winner : '0;

    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_player
        bcd_counter #(
            .DIGITS (DIGITS)
        ) u_score (
            .clk_i   (clk),
            .rst_ni  (clear_b),
            .clr_i   (new_match),
            .inc_i   (inc[p]),
            .count_o (scores_bcd[p*W +: W])
        );
    end

    always_comb begin
        win_hit = 1'b0;
        if (WIN_SCORE != 0) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                if (inc[p] && scores_bcd[p*W +: W] == WIN_PREV_BCD) win_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (new_match) begin
            state_d  = StPlay;
            winner_d = '0;
        end else if (win_hit) begin
            state_d  = StOver;
            winner_d = round_winner;
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q  <= StPlay;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    assign match_over   = (state_q == StOver);
    assign match_winner = winner_q;

`ifdef SCOREBOARD_DRAW_CNT_EN
    logic draw_inc;
    assign draw_inc = accept && !$onehot(round_winner);

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_draw (
        .clk_i   (clk),
        .rst_ni  (clear_b),
        .clr_i   (new_match),
        .inc_i   (draw_inc),
        .count_o (draw_count)
    );
`else
    assign draw_count = '0;
`endif

    for (genvar k = 0; k < int'(NUM_PLAYERS * DIGITS); k++) begin : g_hex
        assign hex_segs[k*7 +: 7] = seg7(scores_bcd[k*4 +: 4]);
    end

endmodule
